// File: rtl/montexp_pkg.sv
// Shared types and the rotating-priority search used by the montexp job scheduler.
package montexp_pkg;

  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned MAX_IDW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } rr_pick_t;

  // First set bit of vld scanning last+1 .. nreq-1, then 0 .. last.
  function automatic rr_pick_t next_rr_winner(input logic [MAX_REQ-1:0] vld,
                                              input logic [MAX_IDW-1:0] last,
                                              input int unsigned        nreq);
    rr_pick_t    pick;
    int unsigned cand;
    pick = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      cand = 32'(last) + k;
      if (cand >= nreq) cand = cand - nreq;
      if ((k <= nreq) && !pick.found && vld[cand[MAX_IDW-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = cand[MAX_IDW-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/montexp.sv
// Left-to-right Montgomery exponentiation engine: one square plus conditional
// multiply per exponent bit, fixed latency of EWIDTH cycles after start.
module montexp #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned R_WIDTH = 8,
  parameter int unsigned EWIDTH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   base_i,
  input  logic [EWIDTH-1:0]  exp_i,
  input  logic [WIDTH-1:0]   n_i,
  input  logic [R_WIDTH-1:0] n_prime_i,
  input  logic [WIDTH-1:0]   mont_one_i,
  output logic               done_o,
  output logic [WIDTH-1:0]   result_o
);

  localparam int unsigned CW = (EWIDTH > 1) ? $clog2(EWIDTH) : 1;
  localparam int unsigned SW = 2 * WIDTH + R_WIDTH + 1;
  localparam int unsigned W1 = WIDTH + 1;

  // REDC: a*b*R^-1 mod n, assuming a,b < n < R.
  function automatic logic [WIDTH-1:0] mont_mul(input logic [WIDTH-1:0]   a,
                                                input logic [WIDTH-1:0]   b,
                                                input logic [WIDTH-1:0]   nv,
                                                input logic [R_WIDTH-1:0] np);
    logic [SW-1:0]      t;
    logic [R_WIDTH-1:0] m;
    logic [SW-1:0]      s;
    logic [W1-1:0]      r;
    t = SW'(a) * SW'(b);
    m = R_WIDTH'(t[R_WIDTH-1:0] * np);
    s = t + SW'(m) * SW'(nv);
    r = W1'(s >> R_WIDTH);
    if (r >= {1'b0, nv}) r = r - {1'b0, nv};
    return r[WIDTH-1:0];
  endfunction

  logic              run_q, run_d;
  logic              done_q, done_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  sq_c, mul_c;

  always_comb begin
    run_d  = run_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    sq_c   = mont_mul(acc_q, acc_q, n_i, n_prime_i);
    mul_c  = mont_mul(sq_c, base_i, n_i, n_prime_i);
    if (start_i) begin
      run_d = 1'b1;
      cnt_d = CW'(EWIDTH - 1);
      acc_d = mont_one_i;
    end else if (run_q) begin
      acc_d = exp_i[cnt_q] ? mul_c : sq_c;
      if (cnt_q == '0) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else begin
      run_q  <= run_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
    end
  end

  assign done_o   = done_q;
  assign result_o = acc_q;

endmodule

// File: rtl/montexp_arbiter.sv
// Round-robin scheduler sharing one montexp engine among NREQ requesters,
// one job in flight, result returned on a per-requester response handshake.
module montexp_arbiter
  import montexp_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned R_WIDTH = 8,
  parameter int unsigned EWIDTH  = 8,
  parameter int unsigned IDW     = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        n,
  input  logic [R_WIDTH-1:0]      n_prime,
  input  logic [WIDTH-1:0]        mont_one,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_base,
  input  logic [NREQ*EWIDTH-1:0]  req_exp,
  output logic [NREQ-1:0]         resp_valid,
  input  logic [NREQ-1:0]         resp_ready,
  output logic [WIDTH-1:0]        resp_result,
  output logic [IDW-1:0]          grant_id,
  output logic                    busy,
  output logic [15:0]             jobs_done
);

  arb_state_t         state_q, state_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [WIDTH-1:0]   base_q, base_d;
  logic [EWIDTH-1:0]  exp_q, exp_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic [NREQ-1:0]    resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [15:0]        jobs_q, jobs_d;

  rr_pick_t           pick_c;
  logic               eng_done;
  logic [WIDTH-1:0]   eng_result;

  assign pick_c = next_rr_winner(MAX_REQ'(req_valid), MAX_IDW'(last_q), NREQ);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    base_d       = base_q;
    exp_d        = exp_q;
    start_d      = 1'b0;
    resp_valid_d = resp_valid_q;
    result_d     = result_q;
    jobs_d       = jobs_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        // Accept strobe is combinational so the handshake closes this cycle.
        if (pick_c.found) begin
          req_ready = NREQ'(1) << pick_c.idx;
          grant_d   = IDW'(pick_c.idx);
          base_d    = req_base[int'(pick_c.idx) * WIDTH +: WIDTH];
          exp_d     = req_exp[int'(pick_c.idx) * EWIDTH +: EWIDTH];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        start_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          result_d     = eng_result;
          resp_valid_d = NREQ'(1) << grant_q;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready[grant_q]) begin
          resp_valid_d = '0;
          last_d       = grant_q;
          jobs_d       = jobs_q + 16'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_q       <= IDW'(NREQ - 1);
      base_q       <= '0;
      exp_q        <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= '0;
      result_q     <= '0;
      jobs_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      base_q       <= base_d;
      exp_q        <= exp_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      result_q     <= result_d;
      jobs_q       <= jobs_d;
    end
  end

  montexp #(
    .WIDTH   (WIDTH),
    .R_WIDTH (R_WIDTH),
    .EWIDTH  (EWIDTH)
  ) u_montexp (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_q),
    .base_i     (base_q),
    .exp_i      (exp_q),
    .n_i        (n),
    .n_prime_i  (n_prime),
    .mont_one_i (mont_one),
    .done_o     (eng_done),
    .result_o   (eng_result)
  );

  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign jobs_done   = jobs_q;

endmodule

// File: tb/tb_montexp_arbiter.sv
// Directed bench for montexp_arbiter: n=13, R=256, n_prime=59, mont_one=9.
module tb_montexp_arbiter;

  logic        clk;
  logic        rst;
  logic [7:0]  n, n_prime, mont_one;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_base, req_exp;
  logic [3:0]  resp_valid, resp_ready;
  logic [7:0]  resp_result;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] jobs_done;

  int n_checks;
  int n_errors;
  int g[5];
  int ng;
  bit switched;
  bit bad;

  montexp_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .n           (n),
    .n_prime     (n_prime),
    .mont_one    (mont_one),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_base    (req_base),
    .req_exp     (req_exp),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .grant_id    (grant_id),
    .busy        (busy),
    .jobs_done   (jobs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic accept(input int idx, input logic [7:0] b, input logic [7:0] e);
    int c;
    req_base[idx*8 +: 8] = b;
    req_exp[idx*8 +: 8]  = e;
    req_valid[idx]       = 1'b1;
    #1;
    c = 0;
    while (req_ready == 4'd0 && c < 100) begin
      tick();
      c++;
    end
    check("accept_ready", 32'(req_ready), 32'(1) << idx);
    tick();
    req_valid[idx] = 1'b0;
    #1;
    check("ready_pulse", 32'(req_ready), 32'd0);
    check("grant_id", 32'(grant_id), 32'(idx));
    check("busy_on", 32'(busy), 32'd1);
  endtask

  task automatic wait_resp();
    int c;
    c = 0;
    while (resp_valid == 4'd0 && c < 100) begin
      tick();
      c++;
    end
    check("resp_timeout", 32'(resp_valid != 4'd0), 32'd1);
  endtask

  task automatic finish_job(input int idx, input logic [7:0] expv);
    wait_resp();
    check("resp_valid", 32'(resp_valid), 32'(1) << idx);
    check("resp_result", 32'(resp_result), 32'(expv));
    resp_ready[idx] = 1'b1;
    tick();
    resp_ready[idx] = 1'b0;
    check("resp_clear", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int expg[5];
    int c;
    expg = '{0, 1, 2, 0, 2};
    n_checks = 0;
    n_errors = 0;
    n = 8'd13; n_prime = 8'd59; mont_one = 8'd9;
    req_valid = '0; req_base = '0; req_exp = '0; resp_ready = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_result", 32'(resp_result), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_jobs_done", 32'(jobs_done), 32'd0);

    // 1. single job: 2^5 mod 13 = 6, mont form 2
    accept(0, 8'd5, 8'd5);
    finish_job(0, 8'd2);
    check("s1_jobs_done", 32'(jobs_done), 32'd1);

    // 2. exponent zero returns mont_one
    accept(1, 8'd5, 8'd0);
    finish_job(1, 8'd9);
    check("s2_jobs_done", 32'(jobs_done), 32'd2);

    // 3. round-robin order after reset
    do_reset();
    req_base = {4{8'd5}};
    req_exp  = {4{8'd5}};
    resp_ready = 4'hF;
    req_valid  = 4'b0111;
    #1;
    ng = 0;
    switched = 1'b0;
    for (int k = 0; k < 400 && ng < 5; k++) begin
      if (req_ready != 4'd0) begin
        for (int b = 3; b >= 0; b--) if (req_ready[b]) g[ng] = b;
        ng++;
      end
      if (resp_valid != 4'd0) check("rr_result", 32'(resp_result), 32'd2);
      tick();
      if (ng == 3 && !switched) begin
        req_valid = 4'b0101;
        switched = 1'b1;
      end
    end
    req_valid = 4'b0000;
    check("rr_count", 32'(ng), 32'd5);
    for (int k = 0; k < 5; k++) check("rr_grant", 32'(g[k]), 32'(expg[k]));
    c = 0;
    while (busy && c < 100) begin
      tick();
      c++;
    end
    check("rr_idle", 32'(busy), 32'd0);
    resp_ready = 4'h0;
    check("rr_jobs_done", 32'(jobs_done), 32'd5);

    // 4. response backpressure with req1 waiting
    accept(0, 8'd5, 8'd5);
    req_valid[1] = 1'b1;
    wait_resp();
    for (int k = 0; k < 20; k++) begin
      check("bp_hold", {15'd0, resp_valid, resp_result, req_ready, busy},
            {15'd0, 4'b0001, 8'd2, 4'b0000, 1'b1});
      tick();
    end
    resp_ready[0] = 1'b1;
    tick();
    resp_ready[0] = 1'b0;
    check("bp_next_accept", 32'(req_ready), 32'b0010);
    tick();
    req_valid[1] = 1'b0;
    finish_job(1, 8'd2);

    // 5. reset during WAIT drops the job
    accept(2, 8'd5, 8'd5);
    tick();
    tick();
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    do_reset();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_jobs", 32'(jobs_done), 32'd0);
    accept(3, 8'd5, 8'd5);
    finish_job(3, 8'd2);
    check("mid_jobs_after", 32'(jobs_done), 32'd1);

    // 6. withdrawn request while busy is never granted
    accept(0, 8'd5, 8'd5);
    req_base[23:16] = 8'd5;
    req_exp[23:16]  = 8'd5;
    req_valid[2] = 1'b1;
    tick();
    req_valid[2] = 1'b0;
    finish_job(0, 8'd2);
    bad = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (resp_valid != 4'd0 || req_ready != 4'd0 || busy) bad = 1'b1;
      tick();
    end
    check("withdraw_idle", 32'(bad), 32'd0);
    check("withdraw_jobs", 32'(jobs_done), 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/montexp_arbiter.md
Name: montexp_arbiter

Overview:
Round-robin scheduler that shares one montexp engine among NREQ requesters, e.g. the g^m and r^n exponentiation clients of the Paillier encrypt path.
- Accepts one job at a time over a per-requester valid/ready handshake and latches its operands.
- Sequences the engine's start/done protocol.
- Returns the result to the originating requester over a per-requester valid/ready response channel.
- Modulus config (n, n_prime, mont_one) is shared by all requesters.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 8, operand/modulus width
R_WIDTH, 8, Montgomery R = 2^R_WIDTH; width of n_prime
EWIDTH, 8, exponent width
IDW, $clog2(NREQ), requester index width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
n  in  WIDTH  modulus; must be stable while busy=1
n_prime  in  R_WIDTH  -n^-1 mod R; must be stable while busy=1
mont_one  in  WIDTH  R mod n; must be stable while busy=1
req_valid  in  NREQ  per-requester job valid
req_ready  out  NREQ  one-hot accept strobe
req_base  in  NREQ*WIDTH  packed Montgomery-domain bases; slice i belongs to requester i
req_exp  in  NREQ*EWIDTH  packed exponents
resp_valid  out  NREQ  one-hot; result pending for requester i
resp_ready  in  NREQ  per-requester response accept
resp_result  out  WIDTH  result, shared by all requesters; meaningful only under resp_valid
grant_id  out  IDW  index of the job currently owned
busy  out  1  high in every state except IDLE
jobs_done  out  16  count of completed response handshakes; wraps at 2^16

Behaviour:
- Reset (sync, rst=1 at clk edge) drives:
  - state=IDLE; req_ready=0; resp_valid=0; resp_result=0; grant_id=0; busy=0; jobs_done=0.
  - last_grant=NREQ-1, so requester 0 has top priority after reset.
  - The internal engine is reset through the same rst.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning last_grant+1 .. NREQ-1, then 0 .. last_grant.
  - req_ready is combinational: one-hot on the winner, only in IDLE; all zero when no req_valid.
  - The handshake completes in that same cycle. On the edge: latch base/exponent slices of the winner, grant_id<=winner, go to ISSUE.
- ISSUE: drive engine start high for exactly one cycle (registered pulse); go to WAIT.
- WAIT:
  - Hold engine operands from the latched registers.
  - On the engine's one-cycle done pulse: resp_result<=engine result, resp_valid[grant_id]<=1, go to RESP.
  - No timeout.
- RESP:
  - Hold resp_valid and resp_result until resp_ready[grant_id]=1.
  - resp_ready on other indices is ignored.
  - On the handshake edge: resp_valid<=0, last_grant<=grant_id, jobs_done++, go to IDLE.
- No new job is accepted before the previous response handshake. Throughput is 1 job per (engine latency + 4) cycles minimum. Accept-to-resp_valid latency = engine latency + 2 cycles.
- A requester may drop req_valid before being accepted; it is then simply skipped. No grant is issued to a requester whose req_valid=0.
- Simultaneous request and response from the same requester is legal. Its new request is arbitrated in the following IDLE, with lowest priority, because last_grant was just set to it.
- exponent=0: the engine returns mont_one; passed through unchanged.
- rst during WAIT/RESP: job is dropped with no response; the requester must re-issue.
- Changing n/n_prime/mont_one while busy=1 gives an undefined result; it must not hang the FSM.

Decomposition:
- Package montexp_pkg holds:
  - arb_state_t enum (IDLE, ISSUE, WAIT, RESP).
  - The next_rr_winner function (rotating priority search over a NREQ-bit vector).
- One sub-module: montexp, instantiated once with WIDTH/R_WIDTH/EWIDTH passed through.
- Arbitration logic stays inline; no separate arbiter sub-module.

Test Plan:
All scenarios use WIDTH=R_WIDTH=EWIDTH=8, n=13, n_prime=59, mont_one=9.
1. Single job: req0 base=5 (mont form of 2), exp=5 -> req_ready[0] pulses one cycle; resp_valid[0] with resp_result=2 (mont form of 6); jobs_done=1.
2. Exponent zero: req1 base=5, exp=0 -> resp_valid[1], resp_result=9.
3. Round-robin after reset: req_valid=4'b0111 held, resp_ready=1 -> grants 0,1,2 in order. Then req_valid=4'b0101 -> grants 0 then 2. No requester served twice while another waits.
4. Response backpressure: hold resp_ready[0]=0 for 20 cycles with req1 valid -> resp_valid[0] and resp_result stable, req_ready stays 0, busy=1; release -> req1 accepted the next cycle.
5. Reset mid-job: assert rst for 1 cycle during WAIT -> next cycle busy=0, resp_valid=0, jobs_done=0. A fresh req3 job then completes correctly with resp_result=2 for base=5, exp=5.
6. Withdrawn request: req2 valid for 1 cycle while busy, then dropped -> never granted, no resp_valid[2]; arbiter returns to IDLE and idles.
